mips32_prog_loader: RTL

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

---
 rtl/mips32_prog_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
// Receives an instruction image over a byte stream and writes it into the
// core's instruction memory, then releases the core with a one-cycle start.
//
// Frame: N (2 bytes, MSB first), N words of 4 bytes (MSB first), 1 checksum
// byte equal to the XOR of every length and data byte.
//
// Ports:
//   clk1         rising-edge clock
//   rst_n        asynchronous active-low reset
//   go           begin a new load (honoured only in IDLE, DONE or ERR)
//   in_valid     byte-stream source has a byte
//   in_data      byte-stream data
//   in_ready     loader accepts a byte (high in LEN, DATA, CHK)
//   mem_we       one-cycle instruction-memory write strobe
//   mem_addr     word address of the write (holds when mem_we=0)
//   mem_wdata    instruction word to write (holds when mem_we=0)
//   busy         high while a frame is being received
//   done         level: frame loaded with a good checksum
//   error        level: frame rejected (too long or bad checksum)
//   start        one-cycle pulse releasing the core
//   words_loaded number of words written in the current frame
module mips32_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              go,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              start,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal word count is the full memory capacity.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t              state_reg, state_next;
  logic [1:0]          byte_cnt_reg;
  logic [7:0]          len_hi_reg;
  logic [15:0]         len_reg;
  logic [23:0]         word_shift_reg;
  logic [7:0]          xor_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic [15:0]         words_loaded_reg;
  logic                start_reg;

  logic                receiving;
  logic                accept;
  logic [15:0]         len_full;
  logic                last_word;

  assign receiving = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                     (state_reg == S_CHK);
  assign accept    = in_valid && receiving;
  // Length as it will be once the second length byte is taken.
  assign len_full  = {len_hi_reg, in_data};
  // words_loaded_reg is the index of the word currently being assembled.
  assign last_word = (words_loaded_reg == (len_reg - 16'd1));

  // State register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (accept && (byte_cnt_reg == 2'd1)) begin
          if (len_full == 16'd0) begin
            state_next = S_CHK;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            state_next = S_ERR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt_reg == 2'd3) && last_word) begin
          state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          state_next = (in_data == xor_reg) ? S_DONE : S_ERR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte counting, word assembly, checksum and memory write.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg     <= 2'd0;
      len_hi_reg       <= 8'd0;
      len_reg          <= 16'd0;
      word_shift_reg   <= 24'd0;
      xor_reg          <= 8'd0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= 32'd0;
      words_loaded_reg <= 16'd0;
      start_reg        <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      start_reg  <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (go) begin
            byte_cnt_reg     <= 2'd0;
            xor_reg          <= 8'd0;
            words_loaded_reg <= 16'd0;
          end
        end
        S_LEN: begin
          if (accept) begin
            xor_reg <= xor_reg ^ in_data;
            if (byte_cnt_reg == 2'd0) begin
              len_hi_reg   <= in_data;
              byte_cnt_reg <= 2'd1;
            end else begin
              len_reg      <= len_full;
              byte_cnt_reg <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_reg      <= xor_reg ^ in_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              // Only a complete word ever reaches the memory port.
              mem_we_reg       <= 1'b1;
              mem_addr_reg     <= words_loaded_reg[ADDR_W-1:0];
              mem_wdata_reg    <= {word_shift_reg, in_data};
              words_loaded_reg <= words_loaded_reg + 16'd1;
            end else begin
              word_shift_reg <= {word_shift_reg[15:0], in_data};
            end
          end
        end
        S_CHK: begin
          if (accept && (in_data == xor_reg)) begin
            start_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = receiving;
  assign busy         = receiving;
  assign done         = (state_reg == S_DONE);
  assign error        = (state_reg == S_ERR);
  assign start        = start_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign words_loaded = words_loaded_reg;

endmodule
